// File: rtl/game_countdown_timer.sv
// Level-scaled countdown timer: a prescaler divides clk into ticks that count time_left down to
// expiry, with saturating bonus time, pause hold and restart on start.
module game_countdown_timer #(
    parameter int CNT_W       = 4,
    parameter int PRESC_W     = 8,
    parameter int START_VAL   = 3,
    parameter int BASE_PERIOD = 4,
    parameter int LVL_W       = 2,
    parameter int BONUS_VAL   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             pause,
    input  logic             wait_en,
    input  logic [LVL_W-1:0] level,
    input  logic             bonus,
    output logic [CNT_W-1:0] time_left,
    output logic             tick,
    output logic             expire_pulse,
    output logic             expired,
    output logic             running
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSED,
        S_EXPIRED
    } state_t;

    localparam logic [31:0] TL_MAX = (32'd1 << CNT_W) - 32'd1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   time_left_q, time_left_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               tick_q, tick_d;
    logic               expire_pulse_q, expire_pulse_d;

    logic [PRESC_W-1:0] base_period;
    logic [PRESC_W-1:0] shifted_period;
    logic [PRESC_W-1:0] period;
    logic               wrap;
    logic               dec;
    logic [31:0]        net;

    // Shifting the base period right can reach zero; that clamps to one tick per enabled cycle.
    assign base_period    = PRESC_W'(BASE_PERIOD);
    assign shifted_period = base_period >> level;
    assign period         = (shifted_period == '0) ? PRESC_W'(1) : shifted_period;
    assign wrap           = (presc_q >= (period - PRESC_W'(1)));

    always_comb begin
        state_d        = state_q;
        time_left_d    = time_left_q;
        presc_d        = presc_q;
        tick_d         = 1'b0;
        expire_pulse_d = 1'b0;
        dec            = 1'b0;
        net            = 32'(time_left_q);

        if (start) begin
            presc_d     = '0;
            time_left_d = CNT_W'(START_VAL);
            if (START_VAL == 0) begin
                state_d        = S_EXPIRED;
                expire_pulse_d = 1'b1;
            end else begin
                state_d = S_RUN;
            end
        end else begin
            case (state_q)
                S_RUN, S_PAUSED: begin
                    if (pause) begin
                        state_d = S_PAUSED;
                    end else begin
                        state_d = S_RUN;
                        if (wait_en) begin
                            if (wrap) begin
                                presc_d = '0;
                                tick_d  = 1'b1;
                                dec     = 1'b1;
                            end else begin
                                presc_d = presc_q + PRESC_W'(1);
                            end
                        end
                    end

                    // Bonus and decrement combine into one net update, saturating at the top.
                    if (bonus) begin
                        net = net + 32'(BONUS_VAL);
                    end
                    if (dec && (net != 32'd0)) begin
                        net = net - 32'd1;
                    end
                    if (net > TL_MAX) begin
                        net = TL_MAX;
                    end
                    time_left_d = net[CNT_W-1:0];

                    if (dec && (net == 32'd0)) begin
                        state_d        = S_EXPIRED;
                        expire_pulse_d = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            time_left_q    <= '0;
            presc_q        <= '0;
            tick_q         <= 1'b0;
            expire_pulse_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            time_left_q    <= time_left_d;
            presc_q        <= presc_d;
            tick_q         <= tick_d;
            expire_pulse_q <= expire_pulse_d;
        end
    end

    assign time_left    = time_left_q;
    assign tick         = tick_q;
    assign expire_pulse = expire_pulse_q;
    assign expired      = (state_q == S_EXPIRED);
    assign running      = (state_q == S_RUN);

endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: every tick pops an expected time_left from a queue; scenario
// tasks check tick spacing, flags and bonus arithmetic inline.
module tb_game_countdown_timer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       pause;
    logic       wait_en;
    logic [1:0] level;
    logic       bonus;
    logic [3:0] time_left;
    logic       tick;
    logic       expire_pulse;
    logic       expired;
    logic       running;

    int n_checks = 0;
    int n_fail   = 0;
    logic [3:0] exp_q[$];

    game_countdown_timer #(
        .CNT_W(4), .PRESC_W(8), .START_VAL(3), .BASE_PERIOD(4), .LVL_W(2), .BONUS_VAL(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause(pause), .wait_en(wait_en),
        .level(level), .bonus(bonus), .time_left(time_left), .tick(tick),
        .expire_pulse(expire_pulse), .expired(expired), .running(running)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL global_timeout reached without finishing");
        $fatal(1);
    end

    // Scoreboard: each observed tick must match the next queued time_left.
    always @(negedge clk) begin
        if (tick === 1'b1) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_tick got tick with time_left=%0d, expected no tick", time_left);
            end else begin
                logic [3:0] e;
                e = exp_q.pop_front();
                if (time_left !== e) begin
                    n_fail++;
                    $display("FAIL tick_time_left got %0d expected %0d", time_left, e);
                end
            end
        end
    end

    task automatic wait_tick(input int max_cycles, output int n);
        bit found;
        found = 1'b0;
        n = -1;
        for (int i = 1; i <= max_cycles && !found; i++) begin
            @(negedge clk);
            if (tick === 1'b1) begin
                n = i;
                found = 1'b1;
            end
        end
    endtask

    // Pulse start from a negedge; returns at the negedge after the start edge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; pause = 1'b0; wait_en = 1'b1; level = 2'd0; bonus = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({time_left, tick, expire_pulse, expired, running} !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_outputs got tl=%0d tick=%b xp=%b exp=%b run=%b expected all 0",
                     time_left, tick, expire_pulse, expired, running);
        end
        reset = 1'b1;
        bonus = 1'b1;
        @(negedge clk);
        bonus = 1'b0;
        n_checks++;
        if ({time_left, expired, running} !== 6'h00) begin
            n_fail++;
            $display("FAIL idle_bonus_ignored got tl=%0d exp=%b run=%b expected 0 0 0",
                     time_left, expired, running);
        end
    endtask

    task automatic test_countdown();
        int n;
        level = 2'd0;
        do_start();
        n_checks++;
        if (time_left !== 4'd3 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL start_load got tl=%0d run=%b expected 3 1", time_left, running);
        end
        exp_q.push_back(4'd2); exp_q.push_back(4'd1); exp_q.push_back(4'd0);
        for (int k = 0; k < 3; k++) begin
            wait_tick(20, n);
            n_checks++;
            if (n != 4) begin
                n_fail++;
                $display("FAIL tick_period_l0 got %0d cycles expected 4", n);
            end
            n_checks++;
            if (expire_pulse !== (k == 2)) begin
                n_fail++;
                $display("FAIL expire_pulse_tick%0d got %b expected %b", k, expire_pulse, (k == 2));
            end
        end
        n_checks++;
        if (expired !== 1'b1 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL expired_flag got exp=%b run=%b expected 1 0", expired, running);
        end
        for (int c = 0; c < 20; c++) begin
            bonus = (c % 5 == 0);
            @(negedge clk);
            n_checks++;
            if (expired !== 1'b1 || time_left !== 4'd0 || expire_pulse !== 1'b0) begin
                n_fail++;
                $display("FAIL expired_sticky c=%0d got exp=%b tl=%0d xp=%b expected 1 0 0",
                         c, expired, time_left, expire_pulse);
            end
        end
        bonus = 1'b0;
    endtask

    task automatic test_levels();
        int n;
        for (int lv = 2; lv <= 3; lv++) begin
            level = 2'(lv);
            exp_q.push_back(4'd2); exp_q.push_back(4'd1); exp_q.push_back(4'd0);
            do_start();
            for (int k = 0; k < 3; k++) begin
                wait_tick(10, n);
                n_checks++;
                if (n != 1) begin
                    n_fail++;
                    $display("FAIL tick_period_level%0d got %0d cycles expected 1", lv, n);
                end
            end
            n_checks++;
            if (expired !== 1'b1) begin
                n_fail++;
                $display("FAIL fast_expire_level%0d got %b expected 1", lv, expired);
            end
        end
        // Raise the level mid-period: prescaler already past the new period wraps next cycle.
        level = 2'd0;
        exp_q.push_back(4'd2); exp_q.push_back(4'd1); exp_q.push_back(4'd0);
        do_start();
        repeat (2) @(negedge clk);
        level = 2'd1;
        wait_tick(10, n);
        n_checks++;
        if (n != 1) begin
            n_fail++;
            $display("FAIL level_raise_wrap got %0d cycles expected 1", n);
        end
        for (int k = 0; k < 2; k++) begin
            wait_tick(10, n);
            n_checks++;
            if (n != 2) begin
                n_fail++;
                $display("FAIL tick_period_level1 got %0d cycles expected 2", n);
            end
        end
        level = 2'd0;
    endtask

    task automatic test_pause();
        int n;
        exp_q.push_back(4'd2); exp_q.push_back(4'd1); exp_q.push_back(4'd0);
        do_start();
        repeat (2) @(negedge clk);
        pause = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (running !== 1'b0 || time_left !== 4'd3) begin
                n_fail++;
                $display("FAIL paused_hold c=%0d got run=%b tl=%0d expected 0 3", c, running, time_left);
            end
        end
        pause = 1'b0;
        wait_tick(20, n);
        n_checks++;
        if (n != 2) begin
            n_fail++;
            $display("FAIL pause_remaining got %0d cycles expected 2", n);
        end
        for (int k = 0; k < 2; k++) begin
            wait_tick(20, n);
            n_checks++;
            if (n != 4) begin
                n_fail++;
                $display("FAIL post_pause_period got %0d cycles expected 4", n);
            end
        end
    endtask

    task automatic test_bonus();
        int n;
        exp_q.push_back(4'd2); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
        do_start();
        wait_tick(20, n);
        wait_tick(20, n);
        repeat (3) @(negedge clk);
        bonus = 1'b1;
        @(negedge clk);
        bonus = 1'b0;
        n_checks++;
        if (tick !== 1'b1 || time_left !== 4'd2 || expire_pulse !== 1'b0 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL bonus_at_wrap got tick=%b tl=%0d xp=%b run=%b expected 1 2 0 1",
                     tick, time_left, expire_pulse, running);
        end
        // Restart paused and stack bonuses up towards saturation.
        start = 1'b1; pause = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bonus = 1'b1;
        repeat (5) @(negedge clk);
        bonus = 1'b0;
        n_checks++;
        if (time_left !== 4'd13 || running !== 1'b0) begin
            n_fail++;
            $display("FAIL bonus_paused got tl=%0d run=%b expected 13 0", time_left, running);
        end
        exp_q.push_back(4'd12);
        pause = 1'b0;
        wait_tick(20, n);
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL tick_after_bonus got %0d cycles expected 4", n);
        end
        pause = 1'b1;
        bonus = 1'b1;
        for (int k = 0; k < 3; k++) begin
            logic [3:0] want;
            want = (k == 0) ? 4'd14 : 4'd15;
            @(negedge clk);
            n_checks++;
            if (time_left !== want) begin
                n_fail++;
                $display("FAIL bonus_saturate step%0d got %0d expected %0d", k, time_left, want);
            end
        end
        bonus = 1'b0;
    endtask

    task automatic test_restart();
        int n;
        pause = 1'b0;
        do_start();
        repeat (2) @(negedge clk);
        pause = 1'b1;
        repeat (3) @(negedge clk);
        start = 1'b1; pause = 1'b0;
        @(negedge clk);
        start = 1'b0;
        n_checks++;
        if (time_left !== 4'd3 || running !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_paused got tl=%0d run=%b expected 3 1", time_left, running);
        end
        exp_q.push_back(4'd2); exp_q.push_back(4'd1); exp_q.push_back(4'd0);
        for (int k = 0; k < 3; k++) begin
            wait_tick(20, n);
            n_checks++;
            if (n != 4) begin
                n_fail++;
                $display("FAIL restart_period got %0d cycles expected 4", n);
            end
        end
        do_start();
        n_checks++;
        if (time_left !== 4'd3 || running !== 1'b1 || expired !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_from_expired got tl=%0d run=%b exp=%b expected 3 1 0",
                     time_left, running, expired);
        end
        exp_q.push_back(4'd2);
        wait_tick(20, n);
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL restart_expired_period got %0d cycles expected 4", n);
        end
    endtask

    task automatic test_reset_mid_run();
        reset = 1'b0;
        start = 1'b1; bonus = 1'b1;
        repeat (2) begin
            @(negedge clk);
            n_checks++;
            if ({time_left, tick, expire_pulse, expired, running} !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_mid_run got tl=%0d tick=%b xp=%b exp=%b run=%b expected all 0",
                         time_left, tick, expire_pulse, expired, running);
            end
        end
        start = 1'b0; bonus = 1'b0;
        reset = 1'b1;
        repeat (8) @(negedge clk);
        n_checks++;
        if (time_left !== 4'd0 || running !== 1'b0 || expired !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got tl=%0d run=%b exp=%b expected 0 0 0",
                     time_left, running, expired);
        end
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_levels();
        test_pause();
        test_bonus();
        test_restart();
        test_reset_mid_run();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_ticks got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
